// File: rtl/instr_prefetch_mem_pkg.sv
// Shared defaults and helpers for the instruction prefetch memory.
package instr_prefetch_mem_pkg;

    localparam int unsigned IMEM_DATA_WIDTH = 32;
    localparam int unsigned IMEM_ADDR_WIDTH = 10;
    localparam int unsigned IMEM_FIFO_DEPTH = 4;
    localparam int unsigned IMEM_RESET_PC   = 0;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int unsigned imem_cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_prefetch_mem_sync_fifo.sv
// Prefetch output FIFO: synchronous push/pop, flush that wins over both, occupancy count.
module instr_prefetch_mem_sync_fifo
    import instr_prefetch_mem_pkg::*;
#(
    parameter int unsigned WIDTH = IMEM_DATA_WIDTH + IMEM_ADDR_WIDTH,
    parameter int unsigned DEPTH = IMEM_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_push,
    input  logic                              i_pop,
    input  logic                              i_flush,
    input  logic [WIDTH-1:0]                  i_data,
    output logic [WIDTH-1:0]                  o_data,
    output logic [imem_cnt_width(DEPTH)-1:0]  o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = imem_cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~i_flush;
    assign w_pop  = i_pop & ~i_flush & (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Head reads as zero whenever the FIFO is empty, so reset/flush show a clean bus.
    assign o_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch_mem.sv
// Instruction memory with sequential prefetcher, redirect/flush and program-load write port.
module instr_prefetch_mem
    import instr_prefetch_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = IMEM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int unsigned FIFO_DEPTH = IMEM_FIFO_DEPTH,
    parameter int unsigned RESET_PC   = IMEM_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int unsigned MEM_DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW        = imem_cnt_width(FIFO_DEPTH);
    localparam int unsigned LW        = CW + 1;
    localparam int unsigned EW        = DATA_WIDTH + ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fpc;
    logic [DATA_WIDTH-1:0] r_rom_q;
    logic [ADDR_WIDTH-1:0] r_rom_a;
    logic                  r_inflight;

    logic [CW-1:0]         w_count;
    logic [LW-1:0]         w_level;
    logic                  w_pop;
    logic                  w_issue;
    logic [EW-1:0]         w_head;

    assign out_valid = (w_count != '0);
    assign w_pop     = out_valid & out_ready;

    // Committed entries after this edge; fetch only while that leaves room for one more.
    assign w_level = LW'(w_count) + LW'(r_inflight) - LW'(w_pop);
    assign w_issue = ~redirect_valid & (w_level < LW'(FIFO_DEPTH));

    // Memory is never cleared by reset; writes are simply blocked while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpc      <= ADDR_WIDTH'(RESET_PC);
            r_rom_q    <= '0;
            r_rom_a    <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (wr_en) begin
                r_mem[wr_addr] <= wr_data;
            end
            if (redirect_valid) begin
                r_fpc      <= redirect_addr;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_rom_q <= r_mem[r_fpc];
                    r_rom_a <= r_fpc;
                    r_fpc   <= r_fpc + ADDR_WIDTH'(1);
                end
            end
        end
    end

    instr_prefetch_mem_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  ({r_rom_a, r_rom_q}),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign {out_addr, out_data} = w_head;

endmodule

// File: tb/tb_instr_prefetch_mem.sv
// Directed self-checking bench for instr_prefetch_mem.
module tb_instr_prefetch_mem;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;
    localparam int unsigned FD = 4;

    logic          clk            = 1'b0;
    logic          rst            = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr  = '0;
    logic          out_ready      = 1'b0;
    logic          wr_en          = 1'b0;
    logic [AW-1:0] wr_addr        = '0;
    logic [DW-1:0] wr_data        = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] wrap_a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [DW-1:0] wrap_d [4] = '{32'h3FE0, 32'h3FF0, 32'h1000, 32'h1001};

    instr_prefetch_mem #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (FD),
        .RESET_PC   (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_addr       (out_addr),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic redir(input logic [AW-1:0] a);
        redirect_valid = 1'b1;
        redirect_addr  = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_addr",  64'(out_addr),  64'd0);

        // Program image through the write port.
        rst = 1'b1;
        for (int i = 0; i < 8; i++) load(AW'(i), DW'(32'h1000 + i));
        for (int i = 0; i < 4; i++) load(AW'(32'h20 + i), DW'(32'h2000 + i));
        load(10'h3FE, 32'h3FE0);
        load(10'h3FF, 32'h3FF0);
        load(10'h010, 32'h5555_0010);

        rst = 1'b0;
        tick();
        chk("rerst_valid", 64'(out_valid), 64'd0);

        // Fill from reset with consumer always ready.
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        chk("fill_lat1", 64'(out_valid), 64'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("fill_valid", 64'(out_valid), 64'd1);
            chk("fill_addr",  64'(out_addr),  64'(i));
            chk("fill_data",  64'(out_data),  64'(32'h1000 + i));
            tick();
        end

        // Back-pressure from reset.
        rst = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c >= 1) begin
                chk("bp_valid", 64'(out_valid), 64'd1);
                chk("bp_head",  64'(out_addr),  64'd0);
            end
        end
        chk("bp_occ", 64'(dut.w_count), 64'(FD));
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("bp_addr", 64'(out_addr), 64'(i));
            chk("bp_data", 64'(out_data), 64'(32'h1000 + i));
            tick();
        end

        // Redirect while full and ready.
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("rd_full", 64'(dut.w_count), 64'(FD));
        out_ready = 1'b1;
        redir(10'h020);
        chk("rd_flush", 64'(out_valid), 64'd0);
        tick();
        chk("rd_gap", 64'(out_valid), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("rd_valid", 64'(out_valid), 64'd1);
            chk("rd_addr",  64'(out_addr),  64'(32'h20 + i));
            chk("rd_data",  64'(out_data),  64'(32'h2000 + i));
            tick();
        end

        // Address wrap at the top of memory.
        redir(10'h3FE);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("wrap_addr", 64'(out_addr), 64'(wrap_a[i]));
            chk("wrap_data", 64'(out_data), 64'(wrap_d[i]));
            tick();
        end

        // Back-to-back redirects: only the last stream survives.
        redirect_valid = 1'b1;
        redirect_addr  = 10'h020;
        tick();
        redirect_addr  = 10'h3FE;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("b2b_gap", 64'(out_valid), 64'd0);
        tick();
        chk("b2b_addr", 64'(out_addr), 64'h3FE);
        chk("b2b_data", 64'(out_data), 64'h3FE0);

        // Same-edge write and fetch of 0x10 returns the old word.
        redir(10'h010);
        wr_en   = 1'b1;
        wr_addr = 10'h010;
        wr_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        tick();
        chk("rbw_addr", 64'(out_addr), 64'h010);
        chk("rbw_old",  64'(out_data), 64'h5555_0010);
        redir(10'h010);
        tick();
        tick();
        chk("load_new", 64'(out_data), 64'hDEAD_BEEF);

        // Asynchronous reset between edges, write attempted during reset.
        chk("pre_rst", 64'(out_valid), 64'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data",  64'(out_data),  64'd0);
        chk("arst_addr",  64'(out_addr),  64'd0);
        wr_en   = 1'b1;
        wr_addr = 10'h010;
        wr_data = 32'h0000_0BAD;
        tick();
        wr_en = 1'b0;
        rst   = 1'b1;
        tick();
        chk("arst_lat", 64'(out_valid), 64'd0);
        tick();
        chk("arst_addr0", 64'(out_addr), 64'd0);
        chk("arst_data0", 64'(out_data), 64'h1000);
        redir(10'h010);
        tick();
        tick();
        chk("retain", 64'(out_data), 64'hDEAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
